aes_decipher_block: RTL and testbench
=====================================

// Module: aes_decipher_block
// PURPOSE
//   Iterative AES inverse cipher (FIPS-197 InvCipher) for 128-bit and 256-bit keys.
//   It is the decrypt counterpart to the encipher round engine and sits beside it in the AES core.
//   Round keys come from the shared key memory, indexed by the round output.
//   InvSubBytes runs one 32-bit word per cycle through an internal combinational inverse S-box (4 bytes).
// PARAMETERS
//   (none). The key length is selected at run time by keylen.
// PORTS
//   clk        in   1    clock; all state updates on the rising edge
//   reset      in   1    synchronous, active-high reset
//   next       in   1    start pulse; sampled only while ready=1
//   keylen     in   1    0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); latched with next
//   round      out  4    current round index; drives the round-key lookup
//   round_key  in   128  key for `round`, combinational, valid the same cycle
//   block      in   128  ciphertext; sampled on the edge that accepts next
//   new_block  out  128  plaintext; valid while ready=1, held until the next start
//   ready      out  1    1 = idle / result valid
// BEHAVIOUR
//   Reset (any state, any cycle)
//     - State words w0..w3 = 0, round = 0, ready = 1, FSM = IDLE, keylen_reg = 0.
//     - Reset mid-operation aborts the operation. The next cycle shows ready=1 and new_block=0.
//   State layout: new_block = {w0,w1,w2,w3}; w0 = bits 127:96.
//   FSM states: IDLE, INIT, SBOX, MAIN.
//   IDLE
//     - When next=1: w <= block, keylen_reg <= keylen, round <= NR (10 or 14), sword_ctr <= 0, ready <= 0, go to INIT.
//     - When next=0: hold all state.
//   INIT
//     - w <= InvShiftRows(w ^ round_key), using round_key[NR].
//     - round <= round-1; go to SBOX.
//   SBOX (4 cycles)
//     - Word w[sword_ctr] <= InvSubWord(w[sword_ctr]); the other words hold.
//     - sword_ctr increments each cycle and wraps 3->0.
//     - Go to MAIN after the cycle with sword_ctr=3.
//   MAIN
//     - If round > 0: w <= InvShiftRows(InvMixColumns(w ^ round_key)); round <= round-1; go to SBOX.
//     - If round == 0: w <= w ^ round_key (final AddRoundKey); ready <= 1; go to IDLE. round stays 0.
//   InvShiftRows output words:
//     ws0 = {w0[31:24], w3[23:16], w2[15:8], w1[7:0]}
//     ws1 = {w1[31:24], w0[23:16], w3[15:8], w2[7:0]}
//     ws2 = {w2[31:24], w1[23:16], w0[15:8], w3[7:0]}
//     ws3 = {w3[31:24], w2[23:16], w1[15:8], w0[7:0]}
//   InvMixColumns, per column [b0..b3]:
//     - mb0 = 14b0 ^ 11b1 ^ 13b2 ^ 9b3, rotating per row.
//     - GF(2^8) arithmetic with polynomial 0x11b.
//   Latency, counted from the edge that accepts next to the edge that sets ready=1:
//     - AES-128: 51 cycles (1 INIT + 10 x (4 SBOX + 1 MAIN)).
//     - AES-256: 71 cycles (1 INIT + 14 x (4 SBOX + 1 MAIN)).
//   Boundary conditions
//     - next while ready=0 is ignored; it is not queued.
//     - next in the same cycle that MAIN finishes is ignored; it is accepted from the following cycle.
//     - keylen and block changes after acceptance have no effect.
//     - round_key is consumed in the INIT and MAIN cycles only.
//     - new_block is undefined while ready=0 (intermediate state is visible).
//   Back-to-back operation: next may be asserted in the first cycle ready=1 is visible.
// TESTING
//   1. FIPS-197 C.1 AES-128
//      - Stimulus: key 000102..0f, block 69c4e0d86a7b0430d8cdb78070b4c55a, next pulse.
//      - Required: new_block = 00112233445566778899aabbccddeeff; ready rises 51 cycles after acceptance.
//   2. FIPS-197 C.3 AES-256
//      - Stimulus: key 000102..1f, block 8ea2b7ca516745bfeafc49904b496089.
//      - Required: new_block = 00112233..eeff after 71 cycles.
//   3. Round sequencing (AES-128)
//      - round = 10 during INIT.
//      - round = 9..0 during the MAIN cycles, each MAIN following exactly 4 SBOX cycles.
//      - No round-key lookup outside 0..10.
//   4. Reset mid-operation
//      - Stimulus: assert reset at cycle 20 of an AES-256 run.
//      - Required next cycle: ready=1, round=0, new_block=0.
//      - A subsequent C.1 run still decrypts correctly.
//   5. Ignored inputs
//      - Stimulus: pulse next, toggle keylen, and change block while ready=0.
//      - Required: result equals the originally latched operation; no restart.
//   6. Back-to-back
//      - Stimulus: C.1 then C.3 with next asserted the first cycle ready=1.
//      - Required: both results correct; second ready 71 cycles after second acceptance.

Source files
------------

// File: rtl/aes_decipher_block.sv
// Iterative AES inverse cipher for 128/256-bit keys: one InvSubWord per cycle,
// with round keys supplied combinationally for the current `round` index.
module aes_decipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
        return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09),
                gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d),
                gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b),
                gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
                inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [31:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = s;
        return {a0[31:24], a3[23:16], a2[15:8], a1[7:0],
                a1[31:24], a0[23:16], a3[15:8], a2[7:0],
                a2[31:24], a1[23:16], a0[15:8], a3[7:0],
                a3[31:24], a2[23:16], a1[15:8], a0[7:0]};
    endfunction

    state_t       state;
    logic [31:0]  w0, w1, w2, w3;
    logic [1:0]   sword_ctr;
    logic [127:0] add_key;
    logic [127:0] init_next;
    logic [127:0] main_next;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;

    assign new_block = {w0, w1, w2, w3};
    assign add_key   = new_block ^ round_key;
    assign init_next = inv_shift_rows(add_key);
    assign main_next = inv_shift_rows(inv_mix_columns(add_key));
    assign sbox_out  = inv_sub_word(sbox_in);

    // NOTE: default assignment first so every path drives sbox_in and no latch is inferred.
    always_comb begin
        sbox_in = w0;
        case (sword_ctr)
            2'd1:    sbox_in = w1;
            2'd2:    sbox_in = w2;
            2'd3:    sbox_in = w3;
            default: sbox_in = w0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            {w0, w1, w2, w3} <= '0;
            round     <= 4'd0;
            sword_ctr <= 2'd0;
            ready     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (next) begin
                        {w0, w1, w2, w3} <= block;
                        round     <= keylen ? 4'd14 : 4'd10;
                        sword_ctr <= 2'd0;
                        ready     <= 1'b0;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    {w0, w1, w2, w3} <= init_next;
                    round <= round - 4'd1;
                    state <= SBOX;
                end
                SBOX: begin
                    case (sword_ctr)
                        2'd0: w0 <= sbox_out;
                        2'd1: w1 <= sbox_out;
                        2'd2: w2 <= sbox_out;
                        2'd3: w3 <= sbox_out;
                        default: ;
                    endcase
                    sword_ctr <= sword_ctr + 2'd1;
                    if (sword_ctr == 2'd3) state <= MAIN;
                end
                MAIN: begin
                    if (round != 4'd0) begin
                        {w0, w1, w2, w3} <= main_next;
                        round <= round - 4'd1;
                        state <= SBOX;
                    end else begin
                        {w0, w1, w2, w3} <= add_key;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decipher_block.sv
// Scoreboard bench for aes_decipher_block using the FIPS-197 C.1 / C.3 vectors;
// round keys are expanded here from the published cipher keys.
module tb_aes_decipher_block;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           nr;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk128 [0:14];
    logic [127:0] rk256 [0:14];
    logic         key_sel;
    exp_t         exp_q[$];
    int           checks;
    int           errors;

    aes_decipher_block dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    assign round_key = key_sel ? rk256[round] : rk128[round];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01; p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand_keys(input bit k256);
        logic [31:0]  ws [0:59];
        logic [255:0] key;
        logic [31:0]  temp;
        logic [7:0]   rcon;
        int nk, nr;
        nk   = k256 ? 8 : 4;
        nr   = k256 ? 14 : 10;
        key  = k256 ? 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
                    : {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) ws[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = ws[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (nk == 8 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            ws[i] = ws[i-nk] ^ temp;
        end
        for (int r = 0; r < 15; r++) begin
            if (r <= nr) begin
                if (k256) rk256[r] = {ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]};
                else      rk128[r] = {ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]};
            end else begin
                if (k256) rk256[r] = 'x;
                else      rk128[r] = 'x;
            end
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", ready, 1'b1);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic issue(input logic [127:0] ct, input bit k256, input bit expect_done);
        exp_t e;
        wait_ready();
        block   = ct;
        keylen  = k256;
        key_sel = k256;
        next    = 1'b1;
        if (expect_done) begin
            e.pt  = PT;
            e.lat = k256 ? 71 : 51;
            e.nr  = k256 ? 14 : 10;
            exp_q.push_back(e);
        end
        @(negedge clk);
        next = 1'b0;
    endtask

    // Monitor: tracks each operation from ready falling to ready rising.
    initial begin : monitor
        bit   prev_ready;
        bit   busy;
        int   cyc;
        int   start;
        int   k;
        int   er;
        exp_t e;
        prev_ready = 1'b1;
        busy       = 1'b0;
        cyc        = 0;
        start      = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                busy       = 1'b0;
                prev_ready = ready;
            end else begin
                if (prev_ready && !ready) begin
                    busy  = 1'b1;
                    start = cyc;
                end
                if (busy && !ready && exp_q.size() > 0) begin
                    k  = cyc - start;
                    er = (k == 0) ? exp_q[0].nr : exp_q[0].nr - 1 - (k - 1) / 5;
                    if (er < 0) er = 0;
                    check("round_seq", round, er);
                end
                if (!prev_ready && ready) begin
                    busy = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got result %h with no operation pending", new_block);
                    end else begin
                        e = exp_q.pop_front();
                        check("plaintext", new_block, e.pt);
                        check("latency", cyc - start, e.lat);
                        check("round_done", round, 4'd0);
                    end
                end
                prev_ready = ready;
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = '0;
        key_sel = 1'b0;
        expand_keys(1'b0);
        expand_keys(1'b1);
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1'b1);
        check("reset_round", round, 4'd0);
        check("reset_block", new_block, 128'h0);
        reset = 1'b0;
        @(negedge clk);

        issue(C1_CT, 1'b0, 1'b1);
        wait_ready();
        issue(C3_CT, 1'b1, 1'b1);
        wait_ready();

        // Abort an AES-256 run partway through, then confirm the engine still works.
        issue(C3_CT, 1'b1, 1'b0);
        repeat (19) @(negedge clk);
        check("busy_before_reset", ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", ready, 1'b1);
        check("abort_round", round, 4'd0);
        check("abort_block", new_block, 128'h0);
        reset = 1'b0;
        @(negedge clk);
        issue(C1_CT, 1'b0, 1'b1);
        wait_ready();

        // Inputs wiggled while busy must not disturb the latched operation.
        issue(C1_CT, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        next = 1'b1;
        for (int i = 0; i < 4; i++) begin
            keylen = ~keylen;
            block  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        next   = 1'b0;
        keylen = 1'b0;
        wait_ready();

        // Back-to-back: second start in the first ready cycle.
        issue(C1_CT, 1'b0, 1'b1);
        wait_ready();
        issue(C3_CT, 1'b1, 1'b1);
        wait_ready();

        // next raised during the final MAIN cycle is only taken one cycle later.
        begin
            exp_t e;
            issue(C1_CT, 1'b0, 1'b1);
            repeat (50) @(negedge clk);
            check("busy_last_main", ready, 1'b0);
            block  = C3_CT;
            keylen = 1'b1;
            next   = 1'b1;
            e.pt   = PT;
            e.lat  = 71;
            e.nr   = 14;
            exp_q.push_back(e);
            @(negedge clk);
            key_sel = 1'b1;
            @(negedge clk);
            next = 1'b0;
            check("second_busy", ready, 1'b0);
            wait_ready();
        end

        repeat (2) @(negedge clk);
        check("pending_ops", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
